seq_regfile_fetch: RTL and testbench

Sequencer and register file that feeds the AND AX,BX execution stage and writes its results back. Holds a 16-entry, 7-bit program store, the 3-bit AX and BX registers, and a program counter. It runs a FETCH/EXEC/WB loop: it drives the opcode and register bits into the combinational execution stage during EXEC, then latches the stage's AX/BX results in WB. This is the control and storage half of the toy CPU datapath.

---
 rtl/seq_regfile_fetch_if.sv | 34 +++
 rtl/seq_regfile_fetch.sv | 137 +++++++++++++
 tb/tb_seq_regfile_fetch.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_regfile_fetch_if.sv
// Bus between the sequencer/register file, its host (program load, start)
// and the combinational AND AX,BX execution stage.
interface seq_regfile_fetch_if;
   logic       start;
   logic       prog_we;
   logic [3:0] prog_addr;
   logic [6:0] prog_data;
   logic       kop1, kop2, kop3, kop4;
   logic       ax1, ax2, ax3;
   logic       bx1, bx2, bx3;
   logic       axx1, axx2, axx3;
   logic       bxx1, bxx2, bxx3;
   logic       busy;
   logic       done;
   logic [3:0] pc;
   logic [2:0] ax_q;
   logic [2:0] bx_q;

   // Host plus execution-stage side
   modport master (
      output start, prog_we, prog_addr, prog_data,
      output axx1, axx2, axx3, bxx1, bxx2, bxx3,
      input  kop1, kop2, kop3, kop4, ax1, ax2, ax3, bx1, bx2, bx3,
      input  busy, done, pc, ax_q, bx_q
   );

   // Sequencer side
   modport slave (
      input  start, prog_we, prog_addr, prog_data,
      input  axx1, axx2, axx3, bxx1, bxx2, bxx3,
      output kop1, kop2, kop3, kop4, ax1, ax2, ax3, bx1, bx2, bx3,
      output busy, done, pc, ax_q, bx_q
   );
endinterface

// File: rtl/seq_regfile_fetch.sv
// FETCH/EXEC/WB sequencer with a 16x7 program store and the AX/BX registers
// feeding the external AND AX,BX execution stage.
module seq_regfile_fetch (
   input logic                clk,
   input logic                rst,
   seq_regfile_fetch_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [3:0] OP_MOV_AX = 4'b0001;
   localparam logic [3:0] OP_MOV_BX = 4'b0010;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   state_t     state_r;
   logic [3:0] pc_r;
   logic [2:0] ax_r;
   logic [2:0] bx_r;
   logic [6:0] ir_r;
   logic [3:0] kop_r;
   logic       busy_r;
   logic       done_r;
   logic [6:0] mem_r [0:15];

   logic [2:0] axx_s;
   logic [2:0] bxx_s;
   logic [3:0] op_s;
   logic [2:0] imm_s;
   logic [2:0] ax_nxt_s;
   logic [2:0] bx_nxt_s;
   logic       store_open_s;

   // Writeback selection: MOV overrides one register with the immediate
   always_comb begin
      axx_s        = {bus.axx3, bus.axx2, bus.axx1};
      bxx_s        = {bus.bxx3, bus.bxx2, bus.bxx1};
      op_s         = ir_r[6:3];
      imm_s        = ir_r[2:0];
      ax_nxt_s     = axx_s;
      bx_nxt_s     = bxx_s;
      store_open_s = (state_r == S_IDLE) || (state_r == S_HALT);
      case (op_s)
         OP_MOV_AX: begin
            ax_nxt_s = imm_s;
            bx_nxt_s = bxx_s;
         end
         OP_MOV_BX: begin
            ax_nxt_s = axx_s;
            bx_nxt_s = imm_s;
         end
         default: begin
            ax_nxt_s = axx_s;
            bx_nxt_s = bxx_s;
         end
      endcase
   end

   // Program store: not reset, writable only while the sequencer is parked
   always_ff @(posedge clk) begin
      if (!rst && bus.prog_we && store_open_s) begin
         mem_r[bus.prog_addr] <= bus.prog_data;
      end
   end

   // Sequencer state, registers and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         pc_r    <= 4'd0;
         ax_r    <= 3'd0;
         bx_r    <= 3'd0;
         ir_r    <= 7'd0;
         kop_r   <= 4'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_HALT: begin
               if (bus.start) begin
                  state_r <= S_FETCH;
                  pc_r    <= 4'd0;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            S_FETCH: begin
               ir_r    <= mem_r[pc_r];
               kop_r   <= mem_r[pc_r][6:3];
               state_r <= S_EXEC;
            end
            S_EXEC: begin
               state_r <= S_WB;
            end
            S_WB: begin
               ax_r  <= ax_nxt_s;
               bx_r  <= bx_nxt_s;
               kop_r <= 4'd0;
               if (op_s == OP_HLT) begin
                  state_r <= S_HALT;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  state_r <= S_FETCH;
                  pc_r    <= pc_r + 4'd1;
               end
            end
            default: begin
               state_r <= S_IDLE;
               kop_r   <= 4'd0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.kop1 = kop_r[3];
   assign bus.kop2 = kop_r[2];
   assign bus.kop3 = kop_r[1];
   assign bus.kop4 = kop_r[0];
   assign bus.ax1  = ax_r[0];
   assign bus.ax2  = ax_r[1];
   assign bus.ax3  = ax_r[2];
   assign bus.bx1  = bx_r[0];
   assign bus.bx2  = bx_r[1];
   assign bus.bx3  = bx_r[2];
   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.pc   = pc_r;
   assign bus.ax_q = ax_r;
   assign bus.bx_q = bx_r;
endmodule

// File: tb/tb_seq_regfile_fetch.sv
// Scoreboard bench for seq_regfile_fetch: per-instruction expectations are
// queued from a reference model at start and retired as each WB commits.
module tb_seq_regfile_fetch;
   typedef struct packed {
      logic [3:0] kop;
      logic [2:0] ax;
      logic [2:0] bx;
      logic [3:0] pc;
      logic       done;
   } exp_t;

   logic clk;
   logic rst;
   seq_regfile_fetch_if bus_if ();

   seq_regfile_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int         n_chk;
   int         n_pass;
   exp_t       sb_q [$];
   logic [6:0] mdl_mem [16];
   logic [2:0] mdl_ax;
   logic [2:0] mdl_bx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Execution stage: AND AX,BX on 0111, pass-through otherwise
   always_comb begin
      if ({bus_if.kop1, bus_if.kop2, bus_if.kop3, bus_if.kop4} == 4'b0111) begin
         {bus_if.axx3, bus_if.axx2, bus_if.axx1} = {bus_if.ax3, bus_if.ax2, bus_if.ax1} &
                                                   {bus_if.bx3, bus_if.bx2, bus_if.bx1};
      end else begin
         {bus_if.axx3, bus_if.axx2, bus_if.axx1} = {bus_if.ax3, bus_if.ax2, bus_if.ax1};
      end
      {bus_if.bxx3, bus_if.bxx2, bus_if.bxx1} = {bus_if.bx3, bus_if.bx2, bus_if.bx1};
   end

   task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic logic [3:0] kop_v();
      return {bus_if.kop1, bus_if.kop2, bus_if.kop3, bus_if.kop4};
   endfunction

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_pc"},   16'(bus_if.pc),   16'd0);
      check_eq({tag, "_ax"},   16'(bus_if.ax_q), 16'd0);
      check_eq({tag, "_bx"},   16'(bus_if.bx_q), 16'd0);
      check_eq({tag, "_kop"},  16'(kop_v()),     16'd0);
      check_eq({tag, "_busy"}, 16'(bus_if.busy), 16'd0);
      check_eq({tag, "_done"}, 16'(bus_if.done), 16'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      mdl_ax = 3'd0;
      mdl_bx = 3'd0;
      sb_q.delete();
      check_idle_zero("reset");
   endtask

   task automatic wr(input logic [3:0] addr, input logic [6:0] data, input bit accept);
      bus_if.prog_we   = 1'b1;
      bus_if.prog_addr = addr;
      bus_if.prog_data = data;
      @(negedge clk);
      bus_if.prog_we = 1'b0;
      if (accept) mdl_mem[addr] = data;
   endtask

   // Reference model: queue one expectation per instruction until HLT
   task automatic plan(input int max_n);
      logic [3:0] p;
      logic [3:0] op;
      logic [2:0] imm;
      exp_t       e;
      p = 4'd0;
      for (int i = 0; i < max_n; i++) begin
         op  = mdl_mem[p][6:3];
         imm = mdl_mem[p][2:0];
         case (op)
            4'b0001: mdl_ax = imm;
            4'b0010: mdl_bx = imm;
            4'b0111: mdl_ax = mdl_ax & mdl_bx;
            default: ;
         endcase
         e.kop  = op;
         e.ax   = mdl_ax;
         e.bx   = mdl_bx;
         e.done = (op == 4'b1111);
         if (!e.done) p = p + 4'd1;
         e.pc = p;
         sb_q.push_back(e);
         if (e.done) break;
      end
   endtask

   task automatic execute(input bit co_we, input logic [3:0] co_addr, input logic [6:0] co_data,
                          input bit busy_wr, input int max_n);
      exp_t e;
      bit   first;
      if (co_we) mdl_mem[co_addr] = co_data;
      plan(max_n);
      bus_if.start     = 1'b1;
      bus_if.prog_we   = co_we;
      bus_if.prog_addr = co_addr;
      bus_if.prog_data = co_data;
      @(negedge clk);
      bus_if.start   = 1'b0;
      bus_if.prog_we = 1'b0;
      check_eq("start_busy", 16'(bus_if.busy), 16'd1);
      check_eq("start_done", 16'(bus_if.done), 16'd0);
      check_eq("fetch_kop",  16'(kop_v()),     16'd0);
      first = 1'b1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         @(negedge clk);
         check_eq("exec_kop", 16'(kop_v()), 16'(e.kop));
         if (busy_wr && first) begin
            bus_if.prog_we   = 1'b1;
            bus_if.prog_addr = 4'd0;
            bus_if.prog_data = 7'b1111000;
         end
         @(negedge clk);
         bus_if.prog_we = 1'b0;
         check_eq("wb_kop", 16'(kop_v()), 16'(e.kop));
         @(negedge clk);
         check_eq("ax_q",   16'(bus_if.ax_q), 16'(e.ax));
         check_eq("bx_q",   16'(bus_if.bx_q), 16'(e.bx));
         check_eq("ax_bus", 16'({bus_if.ax3, bus_if.ax2, bus_if.ax1}), 16'(e.ax));
         check_eq("bx_bus", 16'({bus_if.bx3, bus_if.bx2, bus_if.bx1}), 16'(e.bx));
         check_eq("pc",     16'(bus_if.pc),   16'(e.pc));
         check_eq("done",   16'(bus_if.done), 16'(e.done));
         check_eq("busy",   16'(bus_if.busy), 16'(!e.done));
         if (!e.done) check_eq("fetch_kop", 16'(kop_v()), 16'd0);
         first = 1'b0;
      end
   endtask

   initial begin
      n_chk            = 0;
      n_pass           = 0;
      rst              = 1'b1;
      bus_if.start     = 1'b0;
      bus_if.prog_we   = 1'b0;
      bus_if.prog_addr = 4'd0;
      bus_if.prog_data = 7'd0;
      mdl_ax           = 3'd0;
      mdl_bx           = 3'd0;
      @(negedge clk);
      do_reset();

      // MOV AX,6; MOV BX,3; AND; HLT
      wr(4'd0, 7'b0001_110, 1'b1);
      wr(4'd1, 7'b0010_011, 1'b1);
      wr(4'd2, 7'b0111_000, 1'b1);
      wr(4'd3, 7'b1111_000, 1'b1);
      execute(1'b0, 4'd0, 7'd0, 1'b0, 20);
      @(negedge clk);
      check_eq("done_hold", 16'(bus_if.done), 16'd1);

      // Writes in HALT land: MOV AX,5; MOV BX,3; NOP; HLT
      wr(4'd0, 7'b0001_101, 1'b1);
      wr(4'd2, 7'b0000_000, 1'b1);
      execute(1'b0, 4'd0, 7'd0, 1'b0, 20);

      // Reset with AX=5, BX=3 loaded
      do_reset();

      // MOV AX,7; MOV BX,5; NOP; 0101; HLT written together with start
      wr(4'd0, 7'b0001_111, 1'b1);
      wr(4'd1, 7'b0010_101, 1'b1);
      wr(4'd2, 7'b0000_000, 1'b1);
      wr(4'd3, 7'b0101_000, 1'b1);
      wr(4'd4, 7'b0000_000, 1'b1);
      execute(1'b1, 4'd4, 7'b1111_000, 1'b0, 20);

      // Reset during the AND's EXEC cycle
      do_reset();
      wr(4'd0, 7'b0001_110, 1'b1);
      wr(4'd1, 7'b0010_011, 1'b1);
      wr(4'd2, 7'b0111_000, 1'b1);
      wr(4'd3, 7'b1111_000, 1'b1);
      execute(1'b0, 4'd0, 7'd0, 1'b0, 2);
      @(negedge clk);
      check_eq("abort_exec_kop", 16'(kop_v()), 16'b0111);
      do_reset();
      @(negedge clk);
      check_idle_zero("abort_after");

      // 16 NOPs, no HLT; a write to address 0 while busy must be dropped
      for (int a = 0; a < 16; a++) wr(4'(a), 7'd0, 1'b1);
      execute(1'b0, 4'd0, 7'd0, 1'b1, 17);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
